// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between the fetch and memory stages.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise the data port wins ties.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IReqF,
  input  logic [ADDR_W-1:0] IAdrF,
  input  logic              IAbortF,
  output logic [DATA_W-1:0] IRdataF,
  output logic              IReadyF,
  input  logic              DReqM,
  input  logic              DWeM,
  input  logic [ADDR_W-1:0] DAdrM,
  input  logic [DATA_W-1:0] DWdataM,
  output logic [DATA_W-1:0] DRdataM,
  output logic              DReadyM,
  output logic              BusStallF,
  output logic              BusStallM,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAdr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic [DATA_W-1:0] MemRdata,
  input  logic              MemAck
);

  typedef enum logic [1:0] {IDLE, IBUS, DBUS} state_t;

  state_t state;
  logic   abort_q;
  logic   i_elig, d_elig, grant_i, grant_d;
`ifdef ARB_RR_EN
  logic   prefer_d;
`endif

  // A ready pulse in the current cycle blocks re-granting the request it completes.
  always_comb begin
    i_elig = IReqF & ~IReadyF;
    d_elig = DReqM & ~DReadyM;
`ifdef ARB_RR_EN
    grant_d = d_elig & (~i_elig | prefer_d);
`else
    grant_d = d_elig;
`endif
    grant_i = i_elig & ~grant_d;
  end

  assign BusStallF = IReqF & ~IReadyF;
  assign BusStallM = DReqM & ~DReadyM;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      abort_q  <= 1'b0;
      IRdataF  <= '0;
      IReadyF  <= 1'b0;
      DRdataM  <= '0;
      DReadyM  <= 1'b0;
      MemReq   <= 1'b0;
      MemWe    <= 1'b0;
      MemAdr   <= '0;
      MemWdata <= '0;
`ifdef ARB_RR_EN
      prefer_d <= 1'b1;
`endif
    end else begin
      IReadyF <= 1'b0;
      DReadyM <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state    <= DBUS;
            MemReq   <= 1'b1;
            MemWe    <= DWeM;
            MemAdr   <= DAdrM;
            MemWdata <= DWdataM;
`ifdef ARB_RR_EN
            prefer_d <= 1'b0;
`endif
          end else if (grant_i) begin
            state   <= IBUS;
            MemReq  <= 1'b1;
            MemWe   <= 1'b0;
            MemAdr  <= IAdrF;
            abort_q <= IAbortF;
`ifdef ARB_RR_EN
            prefer_d <= 1'b1;
`endif
          end
        end
        IBUS: begin
          if (IAbortF) abort_q <= 1'b1;
          if (MemAck) begin
            state   <= IDLE;
            MemReq  <= 1'b0;
            abort_q <= 1'b0;
            // An abort raised in the completion cycle still suppresses the result.
            if (!(abort_q || IAbortF)) begin
              IReadyF <= 1'b1;
              IRdataF <= MemRdata;
            end
          end
        end
        DBUS: begin
          if (MemAck) begin
            state   <= IDLE;
            MemReq  <= 1'b0;
            MemWe   <= 1'b0;
            DReadyM <= 1'b1;
            if (!MemWe) DRdataM <= MemRdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; one initial block of steps.
// Expected values are hand-computed; the tie case depends on ARB_RR_EN.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  logic IReqF, IAbortF, IReadyF;
  logic [ADDR_W-1:0] IAdrF;
  logic [DATA_W-1:0] IRdataF;
  logic DReqM, DWeM, DReadyM;
  logic [ADDR_W-1:0] DAdrM;
  logic [DATA_W-1:0] DWdataM, DRdataM;
  logic BusStallF, BusStallM, MemReq, MemWe, MemAck;
  logic [ADDR_W-1:0] MemAdr;
  logic [DATA_W-1:0] MemWdata, MemRdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .IReqF(IReqF), .IAdrF(IAdrF), .IAbortF(IAbortF), .IRdataF(IRdataF), .IReadyF(IReadyF),
    .DReqM(DReqM), .DWeM(DWeM), .DAdrM(DAdrM), .DWdataM(DWdataM), .DRdataM(DRdataM),
    .DReadyM(DReadyM), .BusStallF(BusStallF), .BusStallM(BusStallM),
    .MemReq(MemReq), .MemWe(MemWe), .MemAdr(MemAdr), .MemWdata(MemWdata),
    .MemRdata(MemRdata), .MemAck(MemAck)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_memreq"}, MemReq, 0);
    chk({tag, "_memwe"}, MemWe, 0);
    chk({tag, "_memadr"}, MemAdr, 0);
    chk({tag, "_memwdata"}, MemWdata, 0);
    chk({tag, "_iready"}, IReadyF, 0);
    chk({tag, "_dready"}, DReadyM, 0);
    chk({tag, "_irdata"}, IRdataF, 0);
    chk({tag, "_drdata"}, DRdataM, 0);
  endtask

  logic [ADDR_W-1:0] tie_adr;

  initial begin
    reset = 1'b1;
    IReqF = 0; IAdrF = 0; IAbortF = 0;
    DReqM = 0; DWeM = 0; DAdrM = 0; DWdataM = 0;
    MemRdata = 0; MemAck = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    chk("rst_stallf", BusStallF, 0);
    chk("rst_stallm", BusStallM, 0);
    cyc(); reset = 1'b0;

    // Fetch only, minimum latency
    cyc(); IReqF = 1; IAdrF = 32'h100;
    @(negedge clk);
    chk("f_c0_stall", BusStallF, 1);
    chk("f_c0_memreq", MemReq, 0);
    cyc(); MemAck = 1; MemRdata = 32'hE3A00001;
    @(negedge clk);
    chk("f_c1_memreq", MemReq, 1);
    chk("f_c1_memadr", MemAdr, 32'h100);
    chk("f_c1_memwe", MemWe, 0);
    chk("f_c1_stall", BusStallF, 1);
    cyc(); MemAck = 0;
    @(negedge clk);
    chk("f_c2_iready", IReadyF, 1);
    chk("f_c2_irdata", IRdataF, 32'hE3A00001);
    chk("f_c2_stall", BusStallF, 0);
    chk("f_c2_memreq", MemReq, 0);
    cyc(); IReqF = 0; MemAck = 1; MemRdata = 32'hFFFF0000;
    @(negedge clk);
    chk("f_c3_iready", IReadyF, 0);
    cyc(); MemAck = 0;
    @(negedge clk);
    chk("idleack_iready", IReadyF, 0);
    chk("idleack_dready", DReadyM, 0);
    chk("idleack_memreq", MemReq, 0);
    chk("idleack_irdata", IRdataF, 32'hE3A00001);

    // Simultaneous requests: data write first, then fetch after one IDLE cycle
    cyc(); IReqF = 1; IAdrF = 32'h200; DReqM = 1; DWeM = 1; DAdrM = 32'h40; DWdataM = 32'hDEADBEEF;
    @(negedge clk);
    chk("s_a_stallm", BusStallM, 1);
    cyc(); MemAck = 1; MemRdata = 32'h77777777;
    @(negedge clk);
    chk("s_b_memreq", MemReq, 1);
    chk("s_b_memwe", MemWe, 1);
    chk("s_b_memadr", MemAdr, 32'h40);
    chk("s_b_memwdata", MemWdata, 32'hDEADBEEF);
    cyc(); MemAck = 0;
    @(negedge clk);
    chk("s_c_dready", DReadyM, 1);
    chk("s_c_drdata", DRdataM, 0);
    chk("s_c_memreq", MemReq, 0);
    chk("s_c_stallm", BusStallM, 0);
    chk("s_c_stallf", BusStallF, 1);
    cyc(); DReqM = 0; DWeM = 0; MemAck = 1; MemRdata = 32'h11112222;
    @(negedge clk);
    chk("s_d_memreq", MemReq, 1);
    chk("s_d_memwe", MemWe, 0);
    chk("s_d_memadr", MemAdr, 32'h200);
    chk("s_d_dready", DReadyM, 0);
    cyc(); MemAck = 0;
    @(negedge clk);
    chk("s_e_iready", IReadyF, 1);
    chk("s_e_irdata", IRdataF, 32'h11112222);
    chk("s_e_drdata", DRdataM, 0);
    cyc(); IReqF = 0;

    // Both requests held: grants alternate D, I, D, I
    cyc(); IReqF = 1; IAdrF = 32'h300; DReqM = 1; DWeM = 0; DAdrM = 32'h500;
    for (int k = 0; k < 4; k++) begin
      cyc(); MemAck = 1; MemRdata = DATA_W'(k + 1);
      @(negedge clk);
      chk($sformatf("alt%0d_memreq", k), MemReq, 1);
      chk($sformatf("alt%0d_memadr", k), MemAdr, (k % 2 == 0) ? 32'h500 : 32'h300);
      cyc(); MemAck = 0;
      if (k == 3) begin IReqF = 0; DReqM = 0; end
      @(negedge clk);
      chk($sformatf("alt%0d_dready", k), DReadyM, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("alt%0d_iready", k), IReadyF, (k % 2 == 0) ? 0 : 1);
      if (k % 2 == 0) chk($sformatf("alt%0d_drdata", k), DRdataM, k + 1);
      else            chk($sformatf("alt%0d_irdata", k), IRdataF, k + 1);
    end

    // Abort during IBUS with 3 wait cycles
    cyc(); IReqF = 1; IAdrF = 32'h900;
    cyc(); IAbortF = 1;
    @(negedge clk);
    chk("ab_c1_memreq", MemReq, 1);
    cyc(); IAbortF = 0;
    @(negedge clk);
    chk("ab_c2_memreq", MemReq, 1);
    cyc();
    @(negedge clk);
    chk("ab_c3_memreq", MemReq, 1);
    cyc(); MemAck = 1; MemRdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("ab_c4_memreq", MemReq, 1);
    chk("ab_c4_memadr", MemAdr, 32'h900);
    cyc(); MemAck = 0; IAdrF = 32'hA00;
    @(negedge clk);
    chk("ab_c5_iready", IReadyF, 0);
    chk("ab_c5_irdata", IRdataF, 4);
    chk("ab_c5_memreq", MemReq, 0);
    cyc(); MemAck = 1; MemRdata = 32'h12345678;
    @(negedge clk);
    chk("ab_c6_memadr", MemAdr, 32'hA00);
    cyc(); MemAck = 0;
    @(negedge clk);
    chk("ab_c7_iready", IReadyF, 1);
    chk("ab_c7_irdata", IRdataF, 32'h12345678);
    cyc(); IReqF = 0;

    // Data read alone, then a tie whose winner depends on the policy
    cyc(); DReqM = 1; DWeM = 0; DAdrM = 32'h600;
    cyc(); MemAck = 1; MemRdata = 32'hCAFEF00D;
    cyc(); MemAck = 0;
    @(negedge clk);
    chk("dr_dready", DReadyM, 1);
    chk("dr_drdata", DRdataM, 32'hCAFEF00D);
    cyc(); DReqM = 0;
    cyc(); IReqF = 1; IAdrF = 32'h700; DReqM = 1; DAdrM = 32'h800;
`ifdef ARB_RR_EN
    tie_adr = 32'h700;
`else
    tie_adr = 32'h800;
`endif
    cyc(); MemAck = 1; MemRdata = 32'h0BADF00D;
    @(negedge clk);
    chk("tie_memadr", MemAdr, tie_adr);
    cyc(); MemAck = 0; IReqF = 0; DReqM = 0;
    @(negedge clk);
    chk("tie_iready", IReadyF, (tie_adr == 32'h700) ? 1 : 0);
    chk("tie_dready", DReadyM, (tie_adr == 32'h800) ? 1 : 0);
    cyc();

    // Async reset in DBUS mid-wait, then a fresh read
    cyc(); DReqM = 1; DWeM = 0; DAdrM = 32'hB00;
    cyc();
    @(negedge clk);
    chk("ar_c1_memreq", MemReq, 1);
    cyc();
    #2; reset = 1'b1;
    #1;
    chk_zero("ar");
    cyc(); MemAck = 1; MemRdata = 32'h99999999;
    @(negedge clk);
    chk("ar_hold_dready", DReadyM, 0);
    chk("ar_hold_memreq", MemReq, 0);
    cyc(); reset = 1'b0; MemAck = 0;
    @(negedge clk);
    chk("ar_r0_memreq", MemReq, 0);
    chk("ar_r0_dready", DReadyM, 0);
    cyc(); MemAck = 1; MemRdata = 32'h55AA55AA;
    @(negedge clk);
    chk("ar_r1_memreq", MemReq, 1);
    chk("ar_r1_memadr", MemAdr, 32'hB00);
    cyc(); MemAck = 0;
    @(negedge clk);
    chk("ar_r2_dready", DReadyM, 1);
    chk("ar_r2_drdata", DRdataM, 32'h55AA55AA);
    cyc(); DReqM = 0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data reads/writes) of the pipelined core. It grants one requester at a time, drives the memory handshake, returns read data with a one-cycle ready pulse, and exports per-port stall signals that the hazard unit ORs into its fetch and memory-stage stalls.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports (name, direction, width, meaning):
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- IReqF  in  1  fetch read request; held until IReadyF
- IAdrF  in  ADDR_W  fetch address
- IAbortF  in  1  discard the in-flight fetch (branch or PC redirect)
- IRdataF  out  DATA_W  fetched instruction
- IReadyF  out  1  one-cycle fetch-completion pulse
- DReqM  in  1  data request; held until DReadyM
- DWeM  in  1  1 = write, 0 = read
- DAdrM  in  ADDR_W  data address
- DWdataM  in  DATA_W  write data
- DRdataM  out  DATA_W  load data
- DReadyM  out  1  one-cycle data-completion pulse
- BusStallF  out  1  IReqF & ~IReadyF
- BusStallM  out  1  DReqM & ~DReadyM
- MemReq  out  1  memory transaction active
- MemWe  out  1  memory write enable
- MemAdr  out  ADDR_W  memory address
- MemWdata  out  DATA_W  memory write data
- MemRdata  in  DATA_W  memory read data, valid with MemAck
- MemAck  in  1  memory completion; sampled only while MemReq = 1

## Operation
- FSM states: IDLE, IBUS (serving fetch), DBUS (serving data).
- IDLE:
  - A port is eligible if its request is high and its own ready output is not asserted this cycle. This blocks re-grant of a request that completes at this edge.
  - Neither port eligible: stay in IDLE.
  - One port eligible: grant it.
  - Both eligible: grant per the tie rule in Configuration.
  - On grant, latch address (plus DWeM and DWdataM for data) into the Mem* registers and move to IBUS or DBUS.
- IBUS / DBUS:
  - MemReq = 1, and the Mem* outputs hold the latched values.
  - MemWe = 1 only in DBUS with a latched write.
  - On MemAck, go to IDLE. At the same edge:
    - Pulse the port's ready for one cycle.
    - On reads, capture MemRdata into IRdataF or DRdataM.
    - On writes, DRdataM keeps its previous value.
- IAbortF sets an abort flag when asserted in IBUS, or in IDLE in the cycle a fetch is granted.
  - The transaction still runs to MemAck.
  - At completion, IReadyF stays 0 and IRdataF is not updated. The flag clears.
  - IAbortF has no effect outside these cases.
- Request inputs sampled in IBUS or DBUS are ignored until IDLE.
- Ready outputs and IRdataF/DRdataM are registered. BusStallF/BusStallM are combinational.

## Timing
- Reset values: state IDLE, and every output 0, including IRdataF, DRdataM, MemAdr and MemWdata. Tie pointer favours the data port.
- Reset mid-transaction: MemReq drops asynchronously, the abort flag clears, and no ready pulse is issued. The memory must tolerate an abandoned request.
- Minimum latency, with MemAck in the first MemReq cycle:
  - request high in cycle 0
  - MemReq high in cycle 1
  - ready pulse in cycle 2
- Each memory wait cycle adds one cycle.
- Back-to-back service: IDLE lasts exactly one cycle between transactions, so throughput is at most one transaction per 2 cycles.
- MemAck while in IDLE is ignored.

## Configuration
- ARB_RR_EN defined: round-robin. When both ports are eligible, the port not granted most recently wins. The pointer updates on every grant.
- ARB_RR_EN undefined: fixed priority. The data port always wins ties; the pointer logic is absent.

## Test plan
- Fetch only: IReqF=1, IAdrF=0x100, MemAck in the 1st MemReq cycle with MemRdata=0xE3A00001 -> MemAdr=0x100 in cycle 1; IReadyF=1 and IRdataF=0xE3A00001 in cycle 2; BusStallF=1 in cycles 0–1.
- Simultaneous requests: IReqF and DReqM both high (DWeM=1, DAdrM=0x40, DWdataM=0xDEADBEEF) -> DBUS first with MemWe=1; after DReadyM, IDLE lasts 1 cycle, then IBUS. DRdataM stays 0.
- Arbitration policy, with both requests held continuously:
  - ARB_RR_EN defined: grants alternate D, I, D, I.
  - ARB_RR_EN undefined: data wins every tie.
- Abort: IAbortF pulsed during IBUS with 3 wait cycles -> MemReq held to MemAck, IReadyF stays 0, IRdataF unchanged; the next fetch completes normally.
- Async reset asserted in DBUS mid-wait -> MemReq=0 immediately, all outputs 0, no DReadyM; after release, a fresh read completes with 2-cycle minimum latency.
